// File: rtl/pll_reset_sequencer.sv
// Staged reset release behind a PLL lock flag: the system domain is released after lock has
// been stable for a window, and the peripheral domain follows after a fixed stagger.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGGER_CYCLES     = 16,
    parameter int W_LOSS             = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              loss_count_clr,
    output logic              rst_n_sys,
    output logic              rst_n_periph,
    output logic [W_LOSS-1:0] loss_count
);

    localparam int CNT_MAX = ((LOCK_STABLE_CYCLES > STAGGER_CYCLES) ?
                              LOCK_STABLE_CYCLES : STAGGER_CYCLES) - 1;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        SYS,
        RUN
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_sync;
    logic                   loss_event;

    // Saturating increment: the counter sticks at all-ones rather than wrapping.
    function automatic logic [W_LOSS-1:0] sat_inc(input logic [W_LOSS-1:0] v);
        return (&v) ? v : v + W_LOSS'(1);
    endfunction

    assign lock_sync  = sync_q[SYNC_STAGES-1];
    assign loss_event = ((state == SYS) || (state == RUN)) && !lock_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            state        <= WAIT_LOCK;
            cnt          <= '0;
            rst_n_sys    <= 1'b0;
            rst_n_periph <= 1'b0;
            loss_count   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};

            // A clear wins over a loss seen on the same edge.
            if (loss_count_clr) begin
                loss_count <= '0;
            end else if (loss_event) begin
                loss_count <= sat_inc(loss_count);
            end

            case (state)
                WAIT_LOCK: begin
                    rst_n_sys    <= 1'b0;
                    rst_n_periph <= 1'b0;
                    cnt          <= '0;
                    if (lock_sync) begin
                        state <= STABLE;
                    end
                end
                STABLE: begin
                    if (!lock_sync) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state     <= SYS;
                        cnt       <= '0;
                        rst_n_sys <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SYS: begin
                    if (!lock_sync) begin
                        state        <= WAIT_LOCK;
                        cnt          <= '0;
                        rst_n_sys    <= 1'b0;
                        rst_n_periph <= 1'b0;
                    end else if (cnt == STAGGER_LAST) begin
                        state        <= RUN;
                        cnt          <= '0;
                        rst_n_periph <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_sync) begin
                        state        <= WAIT_LOCK;
                        cnt          <= '0;
                        rst_n_sys    <= 1'b0;
                        rst_n_periph <= 1'b0;
                    end
                end
                default: begin
                    state        <= WAIT_LOCK;
                    cnt          <= '0;
                    rst_n_sys    <= 1'b0;
                    rst_n_periph <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a short stabilisation window and stagger,
// walking through release timing, lock loss, saturation, clear priority and async reset.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       loss_count_clr;
    logic       rst_n_sys;
    logic       rst_n_periph;
    logic [1:0] loss_count;

    int n_asserts = 0;
    int n_fail    = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES       (2),
        .LOCK_STABLE_CYCLES(16),
        .STAGGER_CYCLES    (4),
        .W_LOSS            (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .loss_count_clr(loss_count_clr),
        .rst_n_sys     (rst_n_sys),
        .rst_n_periph  (rst_n_periph),
        .loss_count    (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic sys, input logic per,
                           input logic [1:0] loss);
        chk({tag, ".sys"}, {7'd0, rst_n_sys}, {7'd0, sys});
        chk({tag, ".periph"}, {7'd0, rst_n_periph}, {7'd0, per});
        chk({tag, ".loss"}, {6'd0, loss_count}, {6'd0, loss});
    endtask

    initial begin
        rst_n          = 1'b0;
        pll_locked     = 1'b0;
        loss_count_clr = 1'b0;
        tick(3);
        chk_all("reset", 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        tick(3);
        chk_all("unlocked_idle", 1'b0, 1'b0, 2'd0);

        // 1: lock at edge 0 -> sys at 19, periph at 23
        pll_locked = 1'b1;
        tick(18);
        chk_all("t1_e18", 1'b0, 1'b0, 2'd0);
        tick(1);
        chk_all("t1_e19", 1'b1, 1'b0, 2'd0);
        tick(3);
        chk_all("t1_e22", 1'b1, 1'b0, 2'd0);
        tick(1);
        chk_all("t1_e23", 1'b1, 1'b1, 2'd0);

        // 3: loss in RUN at edge N -> resets low at N+3, then relock repeats timing
        pll_locked = 1'b0;
        tick(2);
        chk_all("t3_n2", 1'b1, 1'b1, 2'd0);
        tick(1);
        chk_all("t3_n3", 1'b0, 1'b0, 2'd1);
        tick(2);
        pll_locked = 1'b1;
        tick(18);
        chk_all("t3_relock_e18", 1'b0, 1'b0, 2'd1);
        tick(1);
        chk_all("t3_relock_e19", 1'b1, 1'b0, 2'd1);
        tick(4);
        chk_all("t3_relock_e23", 1'b1, 1'b1, 2'd1);

        // 5a: async reset while in RUN takes effect before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t5_async_run", 1'b0, 1'b0, 2'd0);
        tick(1);
        rst_n = 1'b1;
        pll_locked = 1'b0;
        tick(3);

        // 2: drop for 2 cycles once cnt=10 (after edge 13) restarts the full window
        pll_locked = 1'b1;
        tick(13);
        pll_locked = 1'b0;
        tick(2);
        chk_all("t2_drop", 1'b0, 1'b0, 2'd0);
        pll_locked = 1'b1;
        tick(18);
        chk_all("t2_restart_e18", 1'b0, 1'b0, 2'd0);
        tick(1);
        chk_all("t2_restart_e19", 1'b1, 1'b0, 2'd0);

        // 6: drop right after sys release (edge N) -> low at N+3, periph never rises
        pll_locked = 1'b0;
        tick(2);
        chk_all("t6_n2", 1'b1, 1'b0, 2'd0);
        tick(1);
        chk_all("t6_n3", 1'b0, 1'b0, 2'd1);
        tick(3);
        chk_all("t6_after", 1'b0, 1'b0, 2'd1);

        // 5b: async reset mid-STABLE clears the counter, then a full sequence is needed
        pll_locked = 1'b1;
        tick(10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t5_async_stable", 1'b0, 1'b0, 2'd0);
        tick(1);
        rst_n = 1'b1;
        tick(18);
        chk_all("t5_post_e18", 1'b0, 1'b0, 2'd0);
        tick(1);
        chk_all("t5_post_e19", 1'b1, 1'b0, 2'd0);
        tick(4);
        chk_all("t5_post_e23", 1'b1, 1'b1, 2'd0);

        // 4: five losses saturate at 3; clear coinciding with a sixth wins
        for (int i = 0; i < 5; i++) begin
            pll_locked = 1'b1;
            tick(20);
            pll_locked = 1'b0;
            tick(3);
            chk_all($sformatf("t4_loss%0d", i + 1), 1'b0, 1'b0, (i < 3) ? 2'(i + 1) : 2'd3);
        end
        pll_locked = 1'b1;
        tick(20);
        chk_all("t4_sys6", 1'b1, 1'b0, 2'd3);
        pll_locked = 1'b0;
        tick(2);
        loss_count_clr = 1'b1;
        tick(1);
        loss_count_clr = 1'b0;
        chk_all("t4_clr_prio", 1'b0, 1'b0, 2'd0);
        tick(2);
        chk_all("t4_clr_hold", 1'b0, 1'b0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
